// File: rtl/mem_bus_if.sv
// SRAM-style memory bus between the arbiter (master) and the external memory bridge (slave).
// The request fields are held stable from the start of the address phase until the bridge accepts it.
interface mem_bus_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              bus_req;
   logic              bus_wr;
   logic [1:0]        bus_size;
   logic [3:0]        bus_sel;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_addr_ok;
   logic              bus_data_ok;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      output bus_req, bus_wr, bus_size, bus_sel, bus_addr, bus_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   modport slave (
      input  bus_req, bus_wr, bus_size, bus_sel, bus_addr, bus_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-style bus between instruction fetch and data access, one transaction at a time.
// Data wins over fetch; returned words are held in registers until the pipeline advances.
module mem_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [3:0]        data_sel,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   input  logic              pipe_advance,
   output logic              stallreq_from_if,
   output logic              stallreq_from_mem,
   mem_bus_if.master         bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic              owner_r;
   logic              inst_done_r;
   logic              data_done_r;
   logic              bus_req_r;
   logic              req_wr_r;
   logic [1:0]        req_size_r;
   logic [3:0]        req_sel_r;
   logic [ADDR_W-1:0] req_addr_r;
   logic [DATA_W-1:0] req_wdata_r;
   logic [DATA_W-1:0] inst_rdata_r;
   logic [DATA_W-1:0] data_rdata_r;
   logic              inst_pend_s;
   logic              data_pend_s;
   logic              latch_inst_s;
   logic              latch_data_s;
   logic              cap_inst_s;
   logic              cap_data_s;

   assign inst_pend_s       = inst_req & ~inst_done_r;
   assign data_pend_s       = data_req & ~data_done_r;
   assign stallreq_from_if  = inst_pend_s;
   assign stallreq_from_mem = data_pend_s;

   assign bus.bus_req   = bus_req_r;
   assign bus.bus_wr    = req_wr_r;
   assign bus.bus_size  = req_size_r;
   assign bus.bus_sel   = req_sel_r;
   assign bus.bus_addr  = req_addr_r;
   assign bus.bus_wdata = req_wdata_r;
   assign inst_rdata    = inst_rdata_r;
   assign data_rdata    = data_rdata_r;

   // Next-state and capture decisions; a fetch whose PC moved on while in flight is dropped
   always_comb begin
      state_nxt_s  = state_r;
      latch_inst_s = 1'b0;
      latch_data_s = 1'b0;
      cap_inst_s   = 1'b0;
      cap_data_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (data_pend_s) begin
               latch_data_s = 1'b1;
               state_nxt_s  = ST_ADDR;
            end else if (inst_pend_s) begin
               latch_inst_s = 1'b1;
               state_nxt_s  = ST_ADDR;
            end else begin
               state_nxt_s  = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (bus.bus_addr_ok) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (bus.bus_data_ok) begin
               state_nxt_s = ST_IDLE;
               if (owner_r) begin
                  cap_data_s = 1'b1;
               end else if (req_addr_r == inst_addr) begin
                  cap_inst_s = 1'b1;
               end else begin
                  cap_inst_s = 1'b0;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, bus request strobe and latched request fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         bus_req_r   <= 1'b0;
         owner_r     <= 1'b0;
         req_wr_r    <= 1'b0;
         req_size_r  <= 2'b00;
         req_sel_r   <= 4'h0;
         req_addr_r  <= {ADDR_W{1'b0}};
         req_wdata_r <= {DATA_W{1'b0}};
      end else begin
         state_r   <= state_nxt_s;
         bus_req_r <= (state_nxt_s == ST_ADDR);
         if (latch_data_s) begin
            owner_r     <= 1'b1;
            req_wr_r    <= data_wr;
            req_size_r  <= data_size;
            req_sel_r   <= data_sel;
            req_addr_r  <= data_addr;
            req_wdata_r <= data_wdata;
         end else if (latch_inst_s) begin
            owner_r     <= 1'b0;
            req_wr_r    <= 1'b0;
            req_size_r  <= 2'b10;
            req_sel_r   <= 4'hF;
            req_addr_r  <= inst_addr;
            req_wdata_r <= {DATA_W{1'b0}};
         end
      end
   end

   // Done flags and returned words; a set in the same cycle as an advance wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_done_r  <= 1'b0;
         data_done_r  <= 1'b0;
         inst_rdata_r <= {DATA_W{1'b0}};
         data_rdata_r <= {DATA_W{1'b0}};
      end else begin
         if (cap_inst_s) begin
            inst_done_r  <= 1'b1;
            inst_rdata_r <= bus.bus_rdata;
         end else if (pipe_advance) begin
            inst_done_r  <= 1'b0;
         end
         if (cap_data_s) begin
            data_done_r  <= 1'b1;
            data_rdata_r <= bus.bus_rdata;
         end else if (pipe_advance) begin
            data_done_r  <= 1'b0;
         end
      end
   end

endmodule
